// File: rtl/rs_ap_ctrl_pipeline_sink_if.sv
// Handshake bundle between the start-token channel, the HLS kernel ap_ctrl
// pins and the upstream done-token channel, as seen by the pipeline sink.
interface rs_ap_ctrl_pipeline_sink_if;
  logic start_if_empty_n;
  logic start_if_dout;
  logic start_if_read;
  logic ap_start;
  logic ap_ready;
  logic ap_done;
  logic ap_idle;
  logic done_if_full_n;
  logic done_if_write;
  logic done_if_din;

  // Sink side: consumes start tokens, drives the kernel, produces done tokens.
  modport slave (
    input  start_if_empty_n, start_if_dout, ap_ready, ap_done, ap_idle, done_if_full_n,
    output start_if_read, ap_start, done_if_write, done_if_din
  );

  // Environment side: token FIFOs plus the kernel.
  modport master (
    output start_if_empty_n, start_if_dout, ap_ready, ap_done, ap_idle, done_if_full_n,
    input  start_if_read, ap_start, done_if_write, done_if_din
  );
endinterface

// File: rtl/rs_ap_ctrl_pipeline_sink.sv
// Kernel-side endpoint of a pipelined ap_ctrl channel: launches the kernel for
// each start token, tracks in-flight invocations and returns done tokens.
module rs_ap_ctrl_pipeline_sink #(
  parameter int unsigned MAX_INFLIGHT   = 2,
  parameter int unsigned DONE_CNT_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  rs_ap_ctrl_pipeline_sink_if.slave bus,
  output logic [3:0]                inflight,
  output logic [DONE_CNT_WIDTH-1:0] pending_done,
  output logic                      err_overflow,
  output logic                      err_spurious
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_START = 1'b1
  } state_t;

  localparam logic [3:0]                MAX_INF  = 4'(MAX_INFLIGHT);
  localparam logic [DONE_CNT_WIDTH-1:0] CNT_MAX  = {DONE_CNT_WIDTH{1'b1}};
  localparam logic [DONE_CNT_WIDTH-1:0] CNT_ZERO = {DONE_CNT_WIDTH{1'b0}};
  localparam logic [DONE_CNT_WIDTH-1:0] CNT_ONE  = CNT_ZERO + 1'b1;

  state_t     state_r;
  logic       ap_start_r;
  logic       accept_s;
  logic       write_s;
  logic       spurious_s;
  logic       retire_s;
  logic       launch_s;
  logic [3:0] inflight_eff_s;
  logic       unused_s;

  assign bus.start_if_read = accept_s;
  assign bus.done_if_write = write_s;
  assign bus.done_if_din   = 1'b0;
  assign bus.ap_start      = ap_start_r;
  assign unused_s          = bus.ap_idle ^ bus.start_if_dout;

  // Handshake decode; the launch test credits a done arriving this same cycle.
  always_comb begin
    accept_s       = (state_r == S_START) && bus.ap_ready;
    write_s        = (pending_done != CNT_ZERO) && bus.done_if_full_n;
    spurious_s     = bus.ap_done && (inflight == 4'd0) && !accept_s;
    retire_s       = bus.ap_done && !spurious_s;
    inflight_eff_s = inflight - {3'b000, (bus.ap_done && (inflight != 4'd0))};
    launch_s       = bus.start_if_empty_n && (inflight_eff_s < MAX_INF);
  end

  // Start FSM with ap_start registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      ap_start_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (launch_s) begin
            state_r    <= S_START;
            ap_start_r <= 1'b1;
          end else begin
            ap_start_r <= 1'b0;
          end
        end
        S_START: begin
          if (accept_s) begin
            state_r    <= S_IDLE;
            ap_start_r <= 1'b0;
          end else begin
            ap_start_r <= 1'b1;
          end
        end
        default: begin
          state_r    <= S_IDLE;
          ap_start_r <= 1'b0;
        end
      endcase
    end
  end

  // In-flight and pending-done counters with sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight     <= 4'd0;
      pending_done <= CNT_ZERO;
      err_overflow <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      case ({accept_s, retire_s})
        2'b10:   inflight <= inflight + 4'd1;
        2'b01:   inflight <= inflight - 4'd1;
        default: inflight <= inflight;
      endcase

      if (spurious_s) begin
        err_spurious <= 1'b1;
      end else begin
        err_spurious <= err_spurious;
      end

      // A done arriving with a saturated count is dropped unless a write frees a slot.
      case ({bus.ap_done, write_s})
        2'b10: begin
          if (pending_done == CNT_MAX) begin
            err_overflow <= 1'b1;
          end else begin
            pending_done <= pending_done + CNT_ONE;
          end
        end
        2'b01:   pending_done <= pending_done - CNT_ONE;
        default: pending_done <= pending_done;
      endcase
    end
  end

endmodule
